// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS deadlock report arbiter.
// Holds the FSM state type, width helpers and the round-robin picker.
package hls_deadlock_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int unsigned MAX_MON   = 32;
    localparam int unsigned MAX_IDX_W = 5;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned h);
        return $clog2(h + 1);
    endfunction

    // First set request strictly after ptr, wrapping modulo n; 0 when none set.
    function automatic logic [MAX_IDX_W-1:0] rr_first(
        input logic [MAX_MON-1:0] req,
        input int unsigned        ptr,
        input int unsigned        n
    );
        logic [MAX_IDX_W-1:0] r;
        logic                 found;
        int unsigned          cand;
        r     = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_MON; k++) begin
            cand = ptr + k;
            if (cand >= n) cand = cand - n;
            if (k <= n && !found && req[cand[MAX_IDX_W-1:0]]) begin
                r     = cand[MAX_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hls_deadlock_debounce.sv
// Per-monitor debounce: saturating persistence counter, armed flag and
// a single confirm pulse per blocked episode.
module hls_deadlock_debounce
    import hls_deadlock_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic enable,
    input  logic mon_block,
    output logic confirm
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD    = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             active;

    assign active  = enable & mon_block;
    assign confirm = active & armed & (cnt == HOLD_M1);

    // Reset leaves the monitor armed so a block still held across reset re-confirms.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cnt   <= '0;
            armed <= 1'b1;
        end else if (active) begin
            if (cnt != HOLD) cnt <= cnt + 1'b1;
            if (confirm)     armed <= 1'b0;
        end else begin
            cnt   <= '0;
            armed <= 1'b1;
        end
    end

endmodule

// File: rtl/hls_deadlock_report_arbiter.sv
// Confirms debounced monitor deadlocks and round-robins them onto a single
// valid/ready report channel; keeps sticky per-monitor status.
module hls_deadlock_report_arbiter
    import hls_deadlock_pkg::*;
#(
    parameter int unsigned NUM_MON     = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned TS_WIDTH    = 32
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic                            enable,
    input  logic [NUM_MON-1:0]              mon_block,
    input  logic                            clear_sticky,
    output logic                            report_valid,
    input  logic                            report_ready,
    output logic [idx_width(NUM_MON)-1:0]   report_idx,
    output logic [TS_WIDTH-1:0]             report_ts,
    output logic [NUM_MON-1:0]              sticky_status,
    output logic                            any_deadlock
);

    localparam int unsigned IDX_W = idx_width(NUM_MON);

    typedef struct packed {
        logic [IDX_W-1:0]    idx;
        logic [TS_WIDTH-1:0] ts;
    } report_t;

    state_t              state, state_nxt;
    report_t             rpt_q, rpt_nxt;
    logic                valid_q;
    logic [IDX_W-1:0]    last_grant, lg_nxt;
    logic [IDX_W-1:0]    sel_idx;
    logic [MAX_IDX_W-1:0] sel;
    logic [MAX_MON-1:0]  req_ext;
    logic [NUM_MON-1:0]  confirm, pending, clr_pend, sticky;
    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] ts_cap [NUM_MON];

    for (genvar g = 0; g < NUM_MON; g++) begin : g_deb
        hls_deadlock_debounce #(
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_deb (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .enable   (enable),
            .mon_block(mon_block[g]),
            .confirm  (confirm[g])
        );
    end

    always_comb begin
        state_nxt = state;
        rpt_nxt   = rpt_q;
        lg_nxt    = last_grant;
        clr_pend  = '0;
        req_ext   = '0;
        req_ext[NUM_MON-1:0] = pending;
        sel       = rr_first(req_ext, 32'(last_grant), NUM_MON);
        sel_idx   = sel[IDX_W-1:0];
        case (state)
            IDLE: begin
                if (|pending) begin
                    rpt_nxt.idx = sel_idx;
                    rpt_nxt.ts  = ts_cap[sel_idx];
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                if (report_ready) begin
                    clr_pend[rpt_q.idx] = 1'b1;
                    lg_nxt              = rpt_q.idx;
                    state_nxt           = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Same-edge confirm is OR-ed in after the grant clear so the new set wins.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            rpt_q      <= '0;
            valid_q    <= 1'b0;
            last_grant <= IDX_W'(NUM_MON - 1);
            ts         <= '0;
            pending    <= '0;
            sticky     <= '0;
            for (int unsigned i = 0; i < NUM_MON; i++) ts_cap[i] <= '0;
        end else begin
            state      <= state_nxt;
            rpt_q      <= rpt_nxt;
            valid_q    <= (state_nxt == SEND);
            last_grant <= lg_nxt;
            ts         <= ts + 1'b1;
            pending    <= (pending & ~clr_pend) | confirm;
            sticky     <= (clear_sticky ? '0 : sticky) | confirm;
            for (int unsigned i = 0; i < NUM_MON; i++) begin
                if (confirm[i]) ts_cap[i] <= ts;
            end
        end
    end

    assign report_valid  = valid_q;
    assign report_idx    = rpt_q.idx;
    assign report_ts     = rpt_q.ts;
    assign sticky_status = sticky;
    assign any_deadlock  = |sticky;

endmodule

// File: tb/tb_hls_deadlock_report_arbiter.sv
// Scoreboard bench for hls_deadlock_report_arbiter: expected reports are queued
// when a monitor is driven and compared at each accepted handshake.
module tb_hls_deadlock_report_arbiter;

    localparam int unsigned NM = 4;
    localparam int unsigned H  = 16;
    localparam int unsigned TW = 32;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          enable;
    logic [NM-1:0] mon_block;
    logic          clear_sticky;
    logic          report_valid;
    logic          report_ready;
    logic [1:0]    report_idx;
    logic [TW-1:0] report_ts;
    logic [NM-1:0] sticky_status;
    logic          any_deadlock;

    typedef struct {
        int unsigned   idx;
        logic [TW-1:0] ts;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    logic [TW-1:0] tb_ts;
    logic [TW-1:0] prev_ts;
    bit            gap_mode = 1'b0;
    bit            have_prev = 1'b0;
    logic [TW-1:0] exp_ts;

    hls_deadlock_report_arbiter #(
        .NUM_MON    (NM),
        .HOLD_CYCLES(H),
        .TS_WIDTH   (TW)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .enable       (enable),
        .mon_block    (mon_block),
        .clear_sticky (clear_sticky),
        .report_valid (report_valid),
        .report_ready (report_ready),
        .report_idx   (report_idx),
        .report_ts    (report_ts),
        .sticky_status(sticky_status),
        .any_deadlock (any_deadlock)
    );

    always #5 ap_clk = ~ap_clk;

    // Reference free-running timestamp.
    always @(posedge ap_clk) tb_ts <= !ap_rst_n ? '0 : tb_ts + 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic expect_report(input int unsigned idx);
        exp_t e;
        e.idx = idx;
        e.ts  = tb_ts + TW'(H - 1);
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) step(1);
        step(3);
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Handshake monitor: valid & ready seen here is accepted at the next edge.
    always @(negedge ap_clk) begin
        if (ap_rst_n === 1'b1 && report_valid === 1'b1 && report_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_occupancy", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rpt_idx", 64'(report_idx), 64'(e.idx));
                check("rpt_ts", 64'(report_ts), 64'(e.ts));
            end
            if (gap_mode) begin
                if (have_prev) check("rpt_gap", 64'(tb_ts - prev_ts), 64'd2);
                prev_ts   = tb_ts;
                have_prev = 1'b1;
            end
        end
    end

    initial begin
        ap_rst_n     = 1'b0;
        enable       = 1'b1;
        mon_block    = '0;
        clear_sticky = 1'b0;
        report_ready = 1'b1;
        step(3);
        ap_rst_n = 1'b1;
        check("rst_valid", 64'(report_valid), 64'd0);
        check("rst_idx", 64'(report_idx), 64'd0);
        check("rst_ts", 64'(report_ts), 64'd0);
        check("rst_sticky", 64'(sticky_status), 64'd0);
        check("rst_any", 64'(any_deadlock), 64'd0);

        // Single monitor held: latency and one report per episode.
        mon_block = 4'b0010;
        expect_report(1);
        step(H);
        check("t1_not_yet_valid", 64'(report_valid), 64'd0);
        step(1);
        check("t1_valid", 64'(report_valid), 64'd1);
        check("t1_sticky", 64'(sticky_status), 64'h2);
        step(30);
        mon_block = '0;
        drain("t1_drain");

        // Interrupted run does not confirm; the following full run does.
        mon_block = 4'b0100;
        step(H - 1);
        mon_block = '0;
        step(1);
        mon_block = 4'b0100;
        expect_report(2);
        step(H + 4);
        mon_block = '0;
        drain("t2_drain");
        check("t2_sticky", 64'(sticky_status), 64'h6);

        // All four at once from fresh pointer, then a second episode.
        ap_rst_n = 1'b0;
        step(1);
        ap_rst_n = 1'b1;
        check("t3_rst_sticky", 64'(sticky_status), 64'd0);
        gap_mode  = 1'b1;
        have_prev = 1'b0;
        mon_block = 4'b1111;
        for (int unsigned i = 0; i < NM; i++) expect_report(i);
        step(H + 10);
        drain("t3_drain_a");
        check("t3_sticky", 64'(sticky_status), 64'hF);
        mon_block = '0;
        step(2);
        have_prev = 1'b0;
        mon_block = 4'b1111;
        for (int unsigned i = 0; i < NM; i++) expect_report(i);
        step(H + 10);
        drain("t3_drain_b");
        mon_block = '0;
        gap_mode  = 1'b0;

        clear_sticky = 1'b1;
        step(1);
        clear_sticky = 1'b0;
        check("clr_sticky", 64'(sticky_status), 64'd0);
        check("clr_any", 64'(any_deadlock), 64'd0);

        // Backpressure: report held stable while ready is low.
        report_ready = 1'b0;
        mon_block    = 4'b0001;
        exp_ts       = tb_ts + TW'(H - 1);
        expect_report(0);
        step(H + 1);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", 64'(report_valid), 64'd1);
            check("t4_hold_idx", 64'(report_idx), 64'd0);
            check("t4_hold_ts", 64'(report_ts), 64'(exp_ts));
            step(1);
        end
        report_ready = 1'b1;
        step(1);
        check("t4_valid_drop", 64'(report_valid), 64'd0);
        mon_block = '0;
        drain("t4_drain");
        check("t4_sticky", 64'(sticky_status), 64'h1);

        // clear_sticky on the confirm edge of monitor 3.
        mon_block = 4'b1000;
        expect_report(3);
        step(H - 1);
        clear_sticky = 1'b1;
        step(1);
        clear_sticky = 1'b0;
        check("t5_sticky", 64'(sticky_status), 64'h8);
        check("t5_any", 64'(any_deadlock), 64'd1);
        mon_block = '0;
        drain("t5_drain");

        // Reset while in SEND drops the report; held block re-confirms.
        report_ready = 1'b0;
        mon_block    = 4'b0010;
        step(H + 1);
        check("t6_in_send", 64'(report_valid), 64'd1);
        ap_rst_n = 1'b0;
        step(1);
        sb.delete();
        check("t6_rst_valid", 64'(report_valid), 64'd0);
        check("t6_rst_sticky", 64'(sticky_status), 64'd0);
        check("t6_rst_any", 64'(any_deadlock), 64'd0);
        ap_rst_n     = 1'b1;
        report_ready = 1'b1;
        expect_report(1);
        step(H);
        check("t6_not_yet_valid", 64'(report_valid), 64'd0);
        step(1);
        check("t6_valid", 64'(report_valid), 64'd1);
        step(2);
        mon_block = '0;
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
